// File: rtl/mtr_drv_n.sv
// Multi-channel H-bridge PWM driver: shared period counter, per-channel
// duty/direction with dead-time on reversal. Optional slew limit: MTR_SLEW_LIM_EN.

module mtr_drv_ch #(
    parameter int W         = 11,
    parameter int DEAD_CYC  = 32,
    parameter int SLEW_STEP = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] cnt,
    input  logic         bnd,
    input  logic [W-1:0] spd,
    input  logic         rev,
    output logic         pwm_f,
    output logic         pwm_r
);
    typedef enum logic {DRV = 1'b0, DEAD = 1'b1} state_t;

    localparam logic [W-1:0] DEAD_LD = W'(DEAD_CYC);
    localparam logic [W-1:0] ONE     = W'(1);

    state_t       state;
    logic [W-1:0] duty_q;
    logic [W-1:0] duty_nxt;
    logic [W-1:0] dead_cnt;
    logic         dir_q;
    logic         dir_pend;
    logic         raw;

    assign raw = (cnt < duty_q);

`ifdef MTR_SLEW_LIM_EN
    localparam logic [W-1:0] STEP = W'(SLEW_STEP);
    always_comb begin
        duty_nxt = spd;
        if (spd > duty_q) begin
            if ((spd - duty_q) > STEP) duty_nxt = duty_q + STEP;
        end else if ((duty_q - spd) > STEP) begin
            duty_nxt = duty_q - STEP;
        end
    end
`else
    assign duty_nxt = spd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DRV;
            duty_q   <= '0;
            dead_cnt <= '0;
            dir_q    <= 1'b0;
            dir_pend <= 1'b0;
            pwm_f    <= 1'b0;
            pwm_r    <= 1'b0;
        end else begin
            pwm_f <= raw & ~dir_q & en & (state == DRV);
            pwm_r <= raw &  dir_q & en & (state == DRV);
            case (state)
                DRV: begin
                    if (bnd) begin
                        duty_q <= duty_nxt;
                        if (rev != dir_q) begin
                            state    <= DEAD;
                            dead_cnt <= DEAD_LD;
                            dir_pend <= rev;
`ifdef MTR_SLEW_LIM_EN
                            // new direction ramps up from standstill
                            duty_q   <= '0;
`endif
                        end
                    end
                end
                DEAD: begin
                    // direction requests are ignored while dead time runs
                    if (bnd) duty_q <= duty_nxt;
                    if (dead_cnt <= ONE) begin
                        dead_cnt <= '0;
                        dir_q    <= dir_pend;
                        state    <= DRV;
                    end else begin
                        dead_cnt <= dead_cnt - ONE;
                    end
                end
                default: state <= DRV;
            endcase
        end
    end
endmodule

module mtr_drv_n #(
    parameter int NUM_CH    = 2,
    parameter int W         = 11,
    parameter int DEAD_CYC  = 32,
    parameter int SLEW_STEP = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_CH*W-1:0] spd,
    input  logic [NUM_CH-1:0]   rev,
    output logic [NUM_CH-1:0]   PWM_frwrd,
    output logic [NUM_CH-1:0]   PWM_rev,
    output logic                prd_strt
);
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] cnt;
    logic         bnd;

    assign bnd = (cnt == CNT_MAX);

    // prd_strt is registered so it is high exactly while cnt == 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_strt <= 1'b0;
        end else begin
            cnt      <= cnt + ONE;
            prd_strt <= bnd;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mtr_drv_ch #(
            .W         (W),
            .DEAD_CYC  (DEAD_CYC),
            .SLEW_STEP (SLEW_STEP)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .cnt   (cnt),
            .bnd   (bnd),
            .spd   (spd[i*W +: W]),
            .rev   (rev[i]),
            .pwm_f (PWM_frwrd[i]),
            .pwm_r (PWM_rev[i])
        );
    end
endmodule
